// File: rtl/psr_pkg.sv
// psr_pkg: shared PSR constants, mode encodings, field positions, bank index and mode-info types
package psr_pkg;
  localparam logic [4:0] MODE_USR = 5'b10000;
  localparam logic [4:0] MODE_FIQ = 5'b10001;
  localparam logic [4:0] MODE_IRQ = 5'b10010;
  localparam logic [4:0] MODE_SVC = 5'b10011;
  localparam logic [4:0] MODE_ABT = 5'b10111;
  localparam logic [4:0] MODE_UND = 5'b11011;
  localparam logic [4:0] MODE_SYS = 5'b11111;
  localparam int N_BIT = 31;
  localparam int Z_BIT = 30;
  localparam int C_BIT = 29;
  localparam int V_BIT = 28;
  localparam int I_BIT = 7;
  localparam int F_BIT = 6;
  localparam int T_BIT = 5;
  localparam int MSK_F = 3;
  localparam int MSK_S = 2;
  localparam int MSK_X = 1;
  localparam int MSK_C = 0;
  localparam int N_BANKS = 5;
  localparam logic [31:0] PSR_RESET = 32'h0000_00D3;
  typedef enum logic [2:0] {
    BANK_FIQ = 3'd0,
    BANK_IRQ = 3'd1,
    BANK_SVC = 3'd2,
    BANK_ABT = 3'd3,
    BANK_UND = 3'd4
  } bank_idx_t;
  typedef struct packed {
    logic legal;
    logic has_spsr;
    logic privileged;
    bank_idx_t bank;
  } mode_info_t;
  function automatic logic [31:0] psr_clean(input logic [31:0] v);
    return {v[N_BIT:V_BIT], 20'h0, v[I_BIT:0]};
  endfunction
endpackage

// File: rtl/psr_bank_if.sv
// psr_bank_if: request/response bundle for psr_bank (en, ALU/MSR/MRS/exception/return requests in; CPSR, MRS data, ret_err out)
interface psr_bank_if;
  logic        en;
  logic        i_nzcv_flag;
  logic [3:0]  i_nzcv_alu;
  logic        i_msr_valid;
  logic        i_msr_spsr;
  logic [3:0]  i_msr_mask;
  logic [31:0] i_msr_data;
  logic        i_mrs_valid;
  logic        i_mrs_spsr;
  logic        i_exc_valid;
  logic [4:0]  i_exc_mode;
  logic        i_ret_valid;
  logic [31:0] o_cpsr;
  logic [3:0]  o_nzcv;
  logic [4:0]  o_mode;
  logic        o_privileged;
  logic [31:0] o_mrs_data;
  logic        o_mrs_valid;
  logic        o_ret_err;
  modport master (
    output en, i_nzcv_flag, i_nzcv_alu, i_msr_valid, i_msr_spsr, i_msr_mask, i_msr_data,
           i_mrs_valid, i_mrs_spsr, i_exc_valid, i_exc_mode, i_ret_valid,
    input  o_cpsr, o_nzcv, o_mode, o_privileged, o_mrs_data, o_mrs_valid, o_ret_err
  );
  modport slave (
    input  en, i_nzcv_flag, i_nzcv_alu, i_msr_valid, i_msr_spsr, i_msr_mask, i_msr_data,
           i_mrs_valid, i_mrs_spsr, i_exc_valid, i_exc_mode, i_ret_valid,
    output o_cpsr, o_nzcv, o_mode, o_privileged, o_mrs_data, o_mrs_valid, o_ret_err
  );
endinterface

// File: rtl/psr_mode_decode.sv
// psr_mode_decode: combinational mode -> {legal, has_spsr, privileged, bank_idx}; in mode[4:0], out info
module psr_mode_decode
  import psr_pkg::*;
(
  input  logic [4:0] mode,
  output mode_info_t info
);
  always_comb begin
    info.legal = 1'b1;
    info.has_spsr = 1'b1;
    info.privileged = mode != MODE_USR;
    info.bank = BANK_FIQ;
    case (mode)
      MODE_USR, MODE_SYS: info.has_spsr = 1'b0;
      MODE_FIQ: info.bank = BANK_FIQ;
      MODE_IRQ: info.bank = BANK_IRQ;
      MODE_SVC: info.bank = BANK_SVC;
      MODE_ABT: info.bank = BANK_ABT;
      MODE_UND: info.bank = BANK_UND;
      default: begin
        info.legal = 1'b0;
        info.has_spsr = 1'b0;
      end
    endcase
  end
endmodule

// File: rtl/psr_bank.sv
// psr_bank: ARMv4 CPSR + five banked SPSRs; ports clk, rst (async high) and psr_bank_if.slave bus
module psr_bank
  import psr_pkg::*;
#(
  parameter logic [31:0] RESET_CPSR = PSR_RESET
) (
  input logic clk,
  input logic rst,
  psr_bank_if.slave bus
);
  logic [31:0] cpsr, cpsr_n, spsr_d, mrs_d, mrs_data;
  logic [31:0] spsr [N_BANKS];
  logic spsr_we, ret_err_n, ret_err, mrs_go, mrs_valid;
  bank_idx_t spsr_idx;
  mode_info_t cur, exc, msr;
  logic unused_ok;
  psr_mode_decode u_cur (.mode(cpsr[4:0]), .info(cur));
  psr_mode_decode u_exc (.mode(bus.i_exc_mode), .info(exc));
  psr_mode_decode u_msr (.mode(bus.i_msr_data[4:0]), .info(msr));
  assign unused_ok = ^{cur.legal, exc.legal, exc.privileged, msr.has_spsr, msr.privileged, msr.bank,
                       bus.i_msr_mask[MSK_S:MSK_X], bus.i_msr_data[27:8]};
  assign mrs_go = bus.en & bus.i_mrs_valid;
  assign mrs_d = bus.i_mrs_spsr ? (cur.has_spsr ? spsr[cur.bank] : '0) : cpsr;
  always_comb begin
    cpsr_n = cpsr;
    spsr_we = 1'b0;
    spsr_idx = exc.bank;
    spsr_d = cpsr;
    ret_err_n = 1'b0;
    if (bus.en) begin
      if (bus.i_exc_valid) begin
        if (exc.has_spsr) begin
          spsr_we = 1'b1;
          cpsr_n[4:0] = bus.i_exc_mode;
          cpsr_n[I_BIT] = 1'b1;
          cpsr_n[T_BIT] = 1'b0;
          cpsr_n[F_BIT] = bus.i_exc_mode == MODE_FIQ ? 1'b1 : cpsr[F_BIT];
        end
      end else if (bus.i_ret_valid) begin
        cpsr_n = cur.has_spsr ? spsr[cur.bank] : cpsr;
        ret_err_n = ~cur.has_spsr;
      end else if (bus.i_msr_valid) begin
        if (bus.i_msr_spsr) begin
          spsr_we = cur.has_spsr;
          spsr_idx = cur.bank;
          spsr_d = spsr[cur.bank];
          spsr_d[N_BIT:V_BIT] = bus.i_msr_mask[MSK_F] ? bus.i_msr_data[N_BIT:V_BIT] : spsr_d[N_BIT:V_BIT];
          spsr_d[I_BIT:0] = bus.i_msr_mask[MSK_C] ? bus.i_msr_data[I_BIT:0] : spsr_d[I_BIT:0];
        end else begin
          cpsr_n[N_BIT:V_BIT] = bus.i_msr_mask[MSK_F] ? bus.i_msr_data[N_BIT:V_BIT] : cpsr[N_BIT:V_BIT];
          if (bus.i_msr_mask[MSK_C] && cur.privileged && msr.legal) begin
            cpsr_n[I_BIT:F_BIT] = bus.i_msr_data[I_BIT:F_BIT];
            cpsr_n[4:0] = bus.i_msr_data[4:0];
          end
        end
      end else if (bus.i_nzcv_flag) begin
        cpsr_n[N_BIT:V_BIT] = bus.i_nzcv_alu;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpsr <= psr_clean(RESET_CPSR);
      for (int i = 0; i < N_BANKS; i++) spsr[i] <= '0;
      mrs_data <= '0;
      mrs_valid <= 1'b0;
      ret_err <= 1'b0;
    end else begin
      cpsr <= cpsr_n;
      if (spsr_we) spsr[spsr_idx] <= spsr_d;
      if (mrs_go) mrs_data <= mrs_d;
      mrs_valid <= mrs_go;
      ret_err <= ret_err_n;
    end
  end
  assign bus.o_cpsr = cpsr;
  assign bus.o_nzcv = cpsr[N_BIT:V_BIT];
  assign bus.o_mode = cpsr[4:0];
  assign bus.o_privileged = cur.privileged;
  assign bus.o_mrs_data = mrs_data;
  assign bus.o_mrs_valid = mrs_valid;
  assign bus.o_ret_err = ret_err;
endmodule

// File: tb/tb_psr_bank.sv
// tb_psr_bank: directed scenarios plus randomized traffic against a behavioural PSR model
module tb_psr_bank;
  localparam logic [4:0] USR = 5'b10000, FIQ = 5'b10001, IRQ = 5'b10010, SVC = 5'b10011;
  localparam logic [4:0] ABT = 5'b10111, UND = 5'b11011, SYS = 5'b11111;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [31:0] m_cpsr, m_mrs_data;
  logic [31:0] m_spsr [32];
  logic m_mrs_valid, m_ret_err;
  logic [4:0] legal_modes [7] = '{USR, FIQ, IRQ, SVC, ABT, UND, SYS};
  logic [4:0] bank_modes [5] = '{FIQ, IRQ, SVC, ABT, UND};
  always #5 clk = ~clk;
  psr_bank_if bus ();
  psr_bank #(.RESET_CPSR(32'h0000_00D3)) dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic bit is_legal(input logic [4:0] m);
    return m inside {USR, FIQ, IRQ, SVC, ABT, UND, SYS};
  endfunction
  function automatic bit is_banked(input logic [4:0] m);
    return m inside {FIQ, IRQ, SVC, ABT, UND};
  endfunction

  task automatic idle();
    bus.en = 1'b1;
    bus.i_nzcv_flag = 1'b0;
    bus.i_nzcv_alu = '0;
    bus.i_msr_valid = 1'b0;
    bus.i_msr_spsr = 1'b0;
    bus.i_msr_mask = '0;
    bus.i_msr_data = '0;
    bus.i_mrs_valid = 1'b0;
    bus.i_mrs_spsr = 1'b0;
    bus.i_exc_valid = 1'b0;
    bus.i_exc_mode = '0;
    bus.i_ret_valid = 1'b0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic msr(input logic to_spsr, input logic [3:0] mask, input logic [31:0] data);
    idle();
    bus.i_msr_valid = 1'b1;
    bus.i_msr_spsr = to_spsr;
    bus.i_msr_mask = mask;
    bus.i_msr_data = data;
  endtask
  task automatic exc(input logic [4:0] mode);
    idle();
    bus.i_exc_valid = 1'b1;
    bus.i_exc_mode = mode;
  endtask
  task automatic mrs(input logic sp);
    idle();
    bus.i_mrs_valid = 1'b1;
    bus.i_mrs_spsr = sp;
  endtask
  task automatic ret();
    idle();
    bus.i_ret_valid = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    checks++; if (bus.o_cpsr !== 32'h0000_00D3) begin errors++; $display("FAIL reset_cpsr got %h want 000000d3", bus.o_cpsr); end
    checks++; if (bus.o_mode !== SVC) begin errors++; $display("FAIL reset_mode got %b want 10011", bus.o_mode); end
    checks++; if (bus.o_mrs_valid !== 1'b0 || bus.o_mrs_data !== 32'h0 || bus.o_ret_err !== 1'b0) begin errors++; $display("FAIL reset_pulses got v=%b d=%h e=%b want 0", bus.o_mrs_valid, bus.o_mrs_data, bus.o_ret_err); end
    checks++; if (bus.o_nzcv !== 4'h0 || bus.o_privileged !== 1'b1) begin errors++; $display("FAIL reset_decode got nzcv=%h priv=%b want 0/1", bus.o_nzcv, bus.o_privileged); end
    tick();
    checks++; if (bus.o_cpsr !== 32'h0000_00D3) begin errors++; $display("FAIL reset_idle got %h want 000000d3", bus.o_cpsr); end
  endtask

  task automatic test_irq_round_trip();
    msr(1'b0, 4'b1001, 32'h6000_0013); tick();
    checks++; if (bus.o_cpsr !== 32'h6000_0013) begin errors++; $display("FAIL msr_cpsr got %h want 60000013", bus.o_cpsr); end
    exc(IRQ); tick();
    checks++; if (bus.o_cpsr !== 32'h6000_0092) begin errors++; $display("FAIL exc_irq got %h want 60000092", bus.o_cpsr); end
    mrs(1'b1); tick();
    checks++; if (bus.o_mrs_valid !== 1'b1 || bus.o_mrs_data !== 32'h6000_0013) begin errors++; $display("FAIL mrs_spsr_irq got v=%b d=%h want 1/60000013", bus.o_mrs_valid, bus.o_mrs_data); end
    ret(); tick();
    checks++; if (bus.o_cpsr !== 32'h6000_0013 || bus.o_mrs_valid !== 1'b0) begin errors++; $display("FAIL ret_irq got %h v=%b want 60000013/0", bus.o_cpsr, bus.o_mrs_valid); end
  endtask

  task automatic test_usr_msr();
    msr(1'b0, 4'b1001, 32'h0000_0010); tick();
    checks++; if (bus.o_cpsr !== 32'h0000_0010 || bus.o_privileged !== 1'b0) begin errors++; $display("FAIL enter_usr got %h priv=%b want 00000010/0", bus.o_cpsr, bus.o_privileged); end
    msr(1'b0, 4'b1001, 32'hF000_00D3); tick();
    checks++; if (bus.o_cpsr !== 32'hF000_0010 || bus.o_privileged !== 1'b0) begin errors++; $display("FAIL usr_msr_c got %h priv=%b want f0000010/0", bus.o_cpsr, bus.o_privileged); end
  endtask

  task automatic test_flag_priority();
    msr(1'b0, 4'b1000, 32'h8000_0000);
    bus.i_nzcv_flag = 1'b1;
    bus.i_nzcv_alu = 4'b0100;
    tick();
    checks++; if (bus.o_cpsr !== 32'h8000_0010 || bus.o_nzcv !== 4'b1000) begin errors++; $display("FAIL msr_over_alu got %h nzcv=%b want 80000010/1000", bus.o_cpsr, bus.o_nzcv); end
    exc(SVC);
    bus.i_nzcv_flag = 1'b1;
    bus.i_nzcv_alu = 4'b1111;
    tick();
    checks++; if (bus.o_cpsr !== 32'h8000_0093 || bus.o_nzcv !== 4'b1000) begin errors++; $display("FAIL exc_over_alu got %h nzcv=%b want 80000093/1000", bus.o_cpsr, bus.o_nzcv); end
    mrs(1'b1); tick();
    checks++; if (bus.o_mrs_data !== 32'h8000_0010) begin errors++; $display("FAIL exc_saved_flags got %h want 80000010", bus.o_mrs_data); end
  endtask

  task automatic test_ret_err_sys();
    msr(1'b0, 4'b0001, 32'h0000_001F); tick();
    checks++; if (bus.o_cpsr !== 32'h8000_001F) begin errors++; $display("FAIL enter_sys got %h want 8000001f", bus.o_cpsr); end
    ret(); tick();
    checks++; if (bus.o_cpsr !== 32'h8000_001F || bus.o_ret_err !== 1'b1) begin errors++; $display("FAIL ret_sys got %h err=%b want 8000001f/1", bus.o_cpsr, bus.o_ret_err); end
    mrs(1'b1); tick();
    checks++; if (bus.o_ret_err !== 1'b0) begin errors++; $display("FAIL ret_err_pulse got %b want 0", bus.o_ret_err); end
    checks++; if (bus.o_mrs_valid !== 1'b1 || bus.o_mrs_data !== 32'h0) begin errors++; $display("FAIL mrs_spsr_sys got v=%b d=%h want 1/0", bus.o_mrs_valid, bus.o_mrs_data); end
  endtask

  task automatic test_illegal_and_en();
    exc(SVC); tick();
    checks++; if (bus.o_cpsr !== 32'h8000_0093) begin errors++; $display("FAIL sys_to_svc got %h want 80000093", bus.o_cpsr); end
    msr(1'b0, 4'b0001, 32'h0000_0015); tick();
    checks++; if (bus.o_cpsr !== 32'h8000_0093) begin errors++; $display("FAIL illegal_mode_msr got %h want 80000093", bus.o_cpsr); end
    exc(FIQ);
    bus.en = 1'b0;
    bus.i_ret_valid = 1'b1;
    bus.i_msr_valid = 1'b1;
    bus.i_msr_mask = 4'b1001;
    bus.i_msr_data = 32'hF000_0010;
    bus.i_nzcv_flag = 1'b1;
    bus.i_nzcv_alu = 4'b0001;
    bus.i_mrs_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (bus.o_cpsr !== 32'h8000_0093 || bus.o_mrs_valid !== 1'b0 || bus.o_ret_err !== 1'b0) begin errors++; $display("FAIL en_low got %h v=%b e=%b want 80000093/0/0", bus.o_cpsr, bus.o_mrs_valid, bus.o_ret_err); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] want [4] = '{32'h8000_0092, 32'h8000_00D1, 32'h8000_0092, 32'h8000_0093};
    exc(IRQ); tick();
    checks++; if (bus.o_cpsr !== want[0]) begin errors++; $display("FAIL b2b_irq got %h want %h", bus.o_cpsr, want[0]); end
    exc(FIQ); tick();
    checks++; if (bus.o_cpsr !== want[1]) begin errors++; $display("FAIL b2b_fiq got %h want %h", bus.o_cpsr, want[1]); end
    ret(); tick();
    checks++; if (bus.o_cpsr !== want[2]) begin errors++; $display("FAIL b2b_ret1 got %h want %h", bus.o_cpsr, want[2]); end
    ret(); tick();
    checks++; if (bus.o_cpsr !== want[3]) begin errors++; $display("FAIL b2b_ret2 got %h want %h", bus.o_cpsr, want[3]); end
  endtask

  task automatic test_async_reset();
    mrs(1'b0); tick();
    idle();
    checks++; if (bus.o_mrs_valid !== 1'b1 || bus.o_mrs_data !== 32'h8000_0093) begin errors++; $display("FAIL pre_reset_mrs got v=%b d=%h want 1/80000093", bus.o_mrs_valid, bus.o_mrs_data); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.o_mrs_valid !== 1'b0 || bus.o_cpsr !== 32'h0000_00D3 || bus.o_mrs_data !== 32'h0) begin errors++; $display("FAIL async_reset got v=%b cpsr=%h d=%h want 0/000000d3/0", bus.o_mrs_valid, bus.o_cpsr, bus.o_mrs_data); end
    #3 rst = 1'b0;
    tick();
  endtask

  task automatic model_step();
    logic [31:0] c, d;
    logic [4:0] md;
    logic [3:0] mk;
    c = m_cpsr;
    md = c[4:0];
    d = bus.i_msr_data;
    mk = bus.i_msr_mask;
    m_ret_err = 1'b0;
    m_mrs_valid = 1'b0;
    if (bus.en) begin
      if (bus.i_mrs_valid) begin
        m_mrs_valid = 1'b1;
        m_mrs_data = bus.i_mrs_spsr ? (is_banked(md) ? m_spsr[md] : 32'h0) : c;
      end
      if (bus.i_exc_valid) begin
        if (is_banked(bus.i_exc_mode)) begin
          m_spsr[bus.i_exc_mode] = c;
          m_cpsr = {c[31:28], 20'h0, 1'b1, bus.i_exc_mode == FIQ ? 1'b1 : c[6], 1'b0, bus.i_exc_mode};
        end
      end else if (bus.i_ret_valid) begin
        if (is_banked(md)) m_cpsr = m_spsr[md];
        else m_ret_err = 1'b1;
      end else if (bus.i_msr_valid) begin
        if (bus.i_msr_spsr) begin
          if (is_banked(md)) m_spsr[md] = {mk[3] ? d[31:28] : m_spsr[md][31:28], 20'h0, mk[0] ? d[7:0] : m_spsr[md][7:0]};
        end else begin
          m_cpsr = {mk[3] ? d[31:28] : c[31:28], 20'h0, (mk[0] && md != USR && is_legal(d[4:0])) ? {d[7:6], c[5], d[4:0]} : c[7:0]};
        end
      end else if (bus.i_nzcv_flag) begin
        m_cpsr = {bus.i_nzcv_alu, c[27:0]};
      end
    end
  endtask

  task automatic test_random();
    logic [4:0] md;
    idle();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    m_cpsr = 32'h0000_00D3;
    m_mrs_data = '0;
    for (int k = 0; k < 32; k++) m_spsr[k] = '0;
    for (int n = 0; n < 400; n++) begin
      md = m_cpsr[4:0];
      idle();
      bus.en = $urandom_range(0, 9) != 0;
      bus.i_nzcv_flag = $urandom_range(0, 2) == 0;
      bus.i_nzcv_alu = 4'($urandom);
      bus.i_msr_valid = $urandom_range(0, 2) == 0;
      bus.i_msr_spsr = $urandom_range(0, 1) == 1;
      bus.i_msr_mask = 4'($urandom);
      bus.i_msr_data = $urandom;
      bus.i_msr_data[4:0] = (!bus.i_msr_spsr && $urandom_range(0, 4) == 0) ? 5'b10101 : legal_modes[$urandom_range(0, 6)];
      bus.i_mrs_valid = $urandom_range(0, 2) == 0;
      bus.i_mrs_spsr = $urandom_range(0, 1) == 1;
      bus.i_exc_valid = $urandom_range(0, 5) == 0;
      bus.i_exc_mode = bank_modes[$urandom_range(0, 4)];
      bus.i_ret_valid = $urandom_range(0, 4) == 0 && (!is_banked(md) || is_legal(m_spsr[md][4:0]));
      model_step();
      tick();
      checks++; if (bus.o_cpsr !== m_cpsr) begin errors++; $display("FAIL rand_cpsr[%0d] got %h want %h", n, bus.o_cpsr, m_cpsr); end
      checks++; if (bus.o_nzcv !== m_cpsr[31:28] || bus.o_mode !== m_cpsr[4:0] || bus.o_privileged !== (m_cpsr[4:0] != USR)) begin errors++; $display("FAIL rand_decode[%0d] got %h/%b/%b for cpsr %h", n, bus.o_nzcv, bus.o_mode, bus.o_privileged, m_cpsr); end
      checks++; if (bus.o_mrs_valid !== m_mrs_valid || bus.o_mrs_data !== m_mrs_data) begin errors++; $display("FAIL rand_mrs[%0d] got v=%b d=%h want v=%b d=%h", n, bus.o_mrs_valid, bus.o_mrs_data, m_mrs_valid, m_mrs_data); end
      checks++; if (bus.o_ret_err !== m_ret_err) begin errors++; $display("FAIL rand_ret_err[%0d] got %b want %b", n, bus.o_ret_err, m_ret_err); end
    end
  endtask

  initial begin
    test_reset();
    test_irq_round_trip();
    test_usr_msr();
    test_flag_priority();
    test_ret_err_sys();
    test_illegal_and_en();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
